// File: rtl/cntr_pkg.sv
// Shared definitions for the arbitrated run counter: FSM states, default sizes
// and a select-width helper.
package cntr_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_CW   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index width for a requester number; a single requester still needs one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cntr_arb_if.sv
// Requester-side bus of cntr_arb: level requests and terminal counts in,
// grant, busy, shared count and completion pulses out.
interface cntr_arb_if
    import cntr_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW
);

    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [CW-1:0]      count;
    logic [NREQ-1:0]    done;

    modport master (output req, len, input gnt, busy, count, done);
    modport slave  (input req, len, output gnt, busy, count, done);

endinterface

// File: rtl/cntr_core.sv
// Shared counter datapath: terminal register, clear/enable counter and the
// terminal compare. The counter saturates at the terminal and never wraps.
module cntr_core
    import cntr_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          load_i,
    input  logic [CW-1:0] term_i,
    output logic [CW-1:0] count_o,
    output logic          at_term_o
);

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] term_q, term_d;

    assign at_term_o = (count_q == term_q);
    assign count_o   = count_q;

    always_comb begin
        term_d  = load_i ? term_i : term_q;
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !at_term_o) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            term_q  <= '0;
        end else begin
            count_q <= count_d;
            term_q  <= term_d;
        end
    end

endmodule

// File: rtl/cntr_arb.sv
// Round-robin arbiter granting one requester at a time a counting run from 0
// up to that requester's terminal value, with abort on request withdrawal.
module cntr_arb
    import cntr_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW
) (
    input  logic       clk,
    input  logic       rst,
    cntr_arb_if.slave  bus
);

    localparam int SW = sel_w(NREQ);

    state_e          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;

    logic [SW-1:0]   pick_idx;
    logic [SW-1:0]   cand;
    logic            pick_valid;
    logic [NREQ-1:0] pick_oh;
    logic [CW-1:0]   len_arr [NREQ];
    logic [CW-1:0]   term_sel;

    logic            core_clr, core_en, core_load, at_term;
    logic [CW-1:0]   count;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign len_arr[gi] = bus.len[gi*CW +: CW];
            assign pick_oh[gi] = (pick_idx == SW'(gi));
        end
    endgenerate

    assign term_sel = len_arr[pick_idx];

    // Search starts just after the previous grantee so every requester gets a turn.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = SW'((int'(last_q) + k) % NREQ);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        core_clr  = 1'b0;
        core_en   = 1'b0;
        core_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = RUN;
                    sel_d     = pick_idx;
                    gnt_d     = pick_oh;
                    core_clr  = 1'b1;
                    core_load = 1'b1;
                end
            end
            RUN: begin
                // Withdrawal wins over completion: an aborted run never pulses done.
                if (!bus.req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = sel_q;
                end else if (at_term) begin
                    state_d = DONE;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                end else begin
                    core_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = sel_q;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SW'(NREQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    cntr_core #(
        .CW(CW)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (core_clr),
        .en_i      (core_en),
        .load_i    (core_load),
        .term_i    (term_sel),
        .count_o   (count),
        .at_term_o (at_term)
    );

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.count = count;

endmodule

// File: tb/tb_cntr_arb.sv
// Self-checking bench for cntr_arb: directed scenarios plus randomized runs
// predicted by a transaction-level round-robin model.
module tb_cntr_arb;

    localparam int N = 4;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          errors = 0;
    int          checks = 0;
    int          m_last = N - 1;
    logic [12:0] e;

    cntr_arb_if #(.NREQ(N), .CW(W)) bus ();

    cntr_arb #(.NREQ(N), .CW(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire [12:0] obs = {bus.gnt, bus.done, bus.busy, bus.count};

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input int i);
        return 4'(1 << i);
    endfunction

    function automatic logic [12:0] ev(input logic [3:0] g, input logic [3:0] d,
                                       input logic b, input int cnt);
        return {g, d, b, 4'(cnt)};
    endfunction

    // Expected winner: rotate the request vector so the search begins after 'last'.
    function automatic int rr_pick(input int last, input logic [3:0] r);
        logic [7:0] dbl;
        dbl = {r, r} >> (last + 1);
        for (int j = 0; j < N; j++) begin
            if (dbl[j]) return (last + 1 + j) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.len = '0;
        repeat (2) step();
        e = ev(4'b0, 4'b0, 1'b0, 0);
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_hold got=%b exp=%b", obs, e); end
        rst = 1'b0;
        step();
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_idle got=%b exp=%b", obs, e); end
        m_last = N - 1;
        $display("reset: outputs idle after release");
    endtask

    task automatic test_round_robin();
        bus.len = {4{4'd1}};
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int s;
            s = k % N;
            for (int c = 0; c <= 1; c++) begin
                step();
                e = ev(oh(s), 4'b0, 1'b1, c);
                checks++; if (obs !== e) begin errors++; $display("FAIL rr_run k=%0d c=%0d got=%b exp=%b", k, c, obs, e); end
            end
            step();
            e = ev(4'b0, oh(s), 1'b0, 1);
            checks++; if (obs !== e) begin errors++; $display("FAIL rr_done k=%0d got=%b exp=%b", k, obs, e); end
            if (k == 4) bus.req = '0;
            step();
            e = ev(4'b0, 4'b0, 1'b0, 1);
            checks++; if (obs !== e) begin errors++; $display("FAIL rr_idle k=%0d got=%b exp=%b", k, obs, e); end
            $display("round_robin: grant to requester %0d", s);
        end
        m_last = 0;
    endtask

    task automatic test_single_run();
        bus.len = {12'd0, 4'd3};
        bus.req = 4'b0001;
        for (int c = 0; c <= 3; c++) begin
            step();
            e = ev(4'b0001, 4'b0, 1'b1, c);
            checks++; if (obs !== e) begin errors++; $display("FAIL single_run c=%0d got=%b exp=%b", c, obs, e); end
        end
        step();
        e = ev(4'b0, 4'b0001, 1'b0, 3);
        checks++; if (obs !== e) begin errors++; $display("FAIL single_done got=%b exp=%b", obs, e); end
        bus.req = '0;
        step();
        e = ev(4'b0, 4'b0, 1'b0, 3);
        checks++; if (obs !== e) begin errors++; $display("FAIL single_idle got=%b exp=%b", obs, e); end
        m_last = 0;
        $display("single_run: requester 0 len 3");
    endtask

    task automatic test_boundary();
        int lv [2];
        lv = '{0, 15};
        for (int i = 0; i < 2; i++) begin
            bus.len = {12'd0, 4'(lv[i])};
            bus.req = 4'b0001;
            for (int c = 0; c <= lv[i]; c++) begin
                step();
                e = ev(4'b0001, 4'b0, 1'b1, c);
                checks++; if (obs !== e) begin errors++; $display("FAIL bound_run len=%0d c=%0d got=%b exp=%b", lv[i], c, obs, e); end
            end
            step();
            e = ev(4'b0, 4'b0001, 1'b0, lv[i]);
            checks++; if (obs !== e) begin errors++; $display("FAIL bound_done len=%0d got=%b exp=%b", lv[i], obs, e); end
            bus.req = '0;
            step();
            e = ev(4'b0, 4'b0, 1'b0, lv[i]);
            checks++; if (obs !== e) begin errors++; $display("FAIL bound_idle len=%0d got=%b exp=%b", lv[i], obs, e); end
            $display("boundary: requester 0 len %0d", lv[i]);
        end
        m_last = 0;
    endtask

    task automatic test_abort();
        bus.len = {8'd0, 4'd0, 4'd7};
        bus.req = 4'b0001;
        for (int c = 0; c <= 2; c++) begin
            step();
            e = ev(4'b0001, 4'b0, 1'b1, c);
            checks++; if (obs !== e) begin errors++; $display("FAIL abort_run c=%0d got=%b exp=%b", c, obs, e); end
        end
        bus.req = 4'b0010;
        step();
        e = ev(4'b0, 4'b0, 1'b0, 2);
        checks++; if (obs !== e) begin errors++; $display("FAIL abort_clear got=%b exp=%b", obs, e); end
        step();
        e = ev(4'b0010, 4'b0, 1'b1, 0);
        checks++; if (obs !== e) begin errors++; $display("FAIL abort_next_grant got=%b exp=%b", obs, e); end
        step();
        e = ev(4'b0, 4'b0010, 1'b0, 0);
        checks++; if (obs !== e) begin errors++; $display("FAIL abort_next_done got=%b exp=%b", obs, e); end
        bus.req = '0;
        step();
        e = ev(4'b0, 4'b0, 1'b0, 0);
        checks++; if (obs !== e) begin errors++; $display("FAIL abort_idle got=%b exp=%b", obs, e); end
        m_last = 1;
        $display("abort: requester 0 dropped at count 2, requester 1 served");
    endtask

    task automatic test_reset_mid_run();
        bus.len = {8'd0, 4'd2, 4'd9};
        bus.req = 4'b0001;
        for (int c = 0; c <= 5; c++) begin
            step();
            e = ev(4'b0001, 4'b0, 1'b1, c);
            checks++; if (obs !== e) begin errors++; $display("FAIL rstmid_run c=%0d got=%b exp=%b", c, obs, e); end
        end
        #3 rst = 1'b1;
        #1;
        e = ev(4'b0, 4'b0, 1'b0, 0);
        checks++; if (obs !== e) begin errors++; $display("FAIL rstmid_async got=%b exp=%b", obs, e); end
        step();
        checks++; if (obs !== e) begin errors++; $display("FAIL rstmid_hold got=%b exp=%b", obs, e); end
        bus.req = 4'b1010;
        rst = 1'b0;
        m_last = N - 1;
        for (int c = 0; c <= 2; c++) begin
            step();
            e = ev(4'b0010, 4'b0, 1'b1, c);
            checks++; if (obs !== e) begin errors++; $display("FAIL rstmid_grant c=%0d got=%b exp=%b", c, obs, e); end
        end
        step();
        e = ev(4'b0, 4'b0010, 1'b0, 2);
        checks++; if (obs !== e) begin errors++; $display("FAIL rstmid_done got=%b exp=%b", obs, e); end
        bus.req = '0;
        step();
        e = ev(4'b0, 4'b0, 1'b0, 2);
        checks++; if (obs !== e) begin errors++; $display("FAIL rstmid_idle got=%b exp=%b", obs, e); end
        m_last = 1;
        $display("reset_mid_run: aborted at count 5, requester 1 first after release");
    endtask

    task automatic test_len_change();
        bus.len = {12'd0, 4'd2};
        bus.req = 4'b0001;
        for (int c = 0; c <= 2; c++) begin
            step();
            e = ev(4'b0001, 4'b0, 1'b1, c);
            checks++; if (obs !== e) begin errors++; $display("FAIL lenchg_run c=%0d got=%b exp=%b", c, obs, e); end
            bus.len = {12'd0, 4'd9};
        end
        step();
        e = ev(4'b0, 4'b0001, 1'b0, 2);
        checks++; if (obs !== e) begin errors++; $display("FAIL lenchg_done got=%b exp=%b", obs, e); end
        bus.req = '0;
        step();
        e = ev(4'b0, 4'b0, 1'b0, 2);
        checks++; if (obs !== e) begin errors++; $display("FAIL lenchg_idle got=%b exp=%b", obs, e); end
        m_last = 0;
        $display("len_change: len0 2 -> 9 mid-run, ended at 2");
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [3:0]  rq;
            logic [15:0] lens;
            int          s, l, ab;
            bit          aborted;
            rq      = 4'($urandom_range(1, 15));
            lens    = 16'($urandom);
            s       = rr_pick(m_last, rq);
            l       = int'(lens[s*4 +: 4]);
            ab      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, l)) : -1;
            aborted = 1'b0;
            bus.req = rq;
            bus.len = lens;
            for (int c = 0; c <= l; c++) begin
                step();
                e = ev(oh(s), 4'b0, 1'b1, c);
                checks++; if (obs !== e) begin errors++; $display("FAIL rand_run t=%0d c=%0d got=%b exp=%b", t, c, obs, e); end
                if (c == ab) begin
                    bus.req[s] = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                // Other requesters and len churn mid-run must not disturb the run.
                bus.len = 16'($urandom);
                bus.req = 4'($urandom) | oh(s);
            end
            if (aborted) begin
                step();
                e = ev(4'b0, 4'b0, 1'b0, ab);
                checks++; if (obs !== e) begin errors++; $display("FAIL rand_abort t=%0d got=%b exp=%b", t, obs, e); end
            end else begin
                step();
                e = ev(4'b0, oh(s), 1'b0, l);
                checks++; if (obs !== e) begin errors++; $display("FAIL rand_done t=%0d got=%b exp=%b", t, obs, e); end
                step();
                e = ev(4'b0, 4'b0, 1'b0, l);
                checks++; if (obs !== e) begin errors++; $display("FAIL rand_idle t=%0d got=%b exp=%b", t, obs, e); end
            end
            m_last = s;
            $display("random txn %0d: req=%b sel=%0d len=%0d abort_at=%0d", t, rq, s, l, ab);
        end
        bus.req = '0;
        step();
    endtask

    initial begin
        bus.req = '0;
        bus.len = '0;
        test_reset();
        test_round_robin();
        test_single_run();
        test_boundary();
        test_abort();
        test_reset_mid_run();
        test_len_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cntr_arb.md
CNTR_ARB -- requirements
Module: cntr_arb

Interface
REQ-001 The module SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the counter.
REQ-002 The module SHALL have parameter CW, default 4, meaning the counter width in bits.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 The module SHALL have port req  input  NREQ  per-requester level request for the counter.
REQ-006 The module SHALL have port len  input  NREQ*CW  per-requester terminal count; requester i's value occupies bits [i*CW +: CW].
REQ-007 The module SHALL have port gnt  output  NREQ  one-hot (or zero) grant, registered.
REQ-008 The module SHALL have port busy  output  1  high while any grant is active.
REQ-009 The module SHALL have port count  output  CW  current shared counter value.
REQ-010 The module SHALL have port done  output  NREQ  one-cycle pulse to the requester whose run completed.

Function
REQ-011 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-012 IDLE: when any req bit is high, the FSM SHALL select a requester round-robin, starting at (last_grantee+1) mod NREQ and taking the first req bit set.
- IDLE, no req: SHALL stay in IDLE.
- On a grant, SHALL latch len[sel] into an internal terminal register.
- On a grant, SHALL set gnt[sel]=1 and count=0, and enter RUN.
REQ-013 RUN: if req[sel] is still high, count SHALL increment by 1 each cycle until count equals the latched terminal; on that cycle the FSM SHALL enter DONE.
REQ-014 len SHALL be sampled only on the grant edge; later changes SHALL have no effect on the current run.
REQ-015 Latency: req rising at edge N (FSM in IDLE) SHALL give gnt and count=0 after edge N+1, count=L after edge N+1+L, and done[sel]=1 with gnt=0 after edge N+2+L.
REQ-016 A latched terminal of 0 SHALL produce exactly one RUN cycle with count=0, then DONE.
REQ-017 count SHALL never exceed the latched terminal and SHALL never wrap; the maximum terminal 2^CW-1 SHALL be reached without overflow.
REQ-018 DONE: done[sel] SHALL be high for exactly one cycle, gnt SHALL be 0, last_grantee SHALL become sel, and the FSM SHALL go to IDLE.
REQ-019 Abort: if req[sel] falls during RUN, the next edge SHALL clear gnt, hold count, update last_grantee to sel, and go to IDLE with no done pulse.
REQ-020 Requests from non-granted requesters during RUN or DONE SHALL be ignored until IDLE, then arbitrated normally.
REQ-021 busy SHALL equal (state==RUN); gnt SHALL be nonzero only in RUN; at most one gnt bit and one done bit SHALL ever be high.
REQ-022 The minimum spacing from one grant's completion to the next grant SHALL be DONE then IDLE, i.e. 2 cycles.

Reset
REQ-023 While rst is high, asynchronously: state SHALL be IDLE, gnt=0, done=0, busy=0, count=0, the terminal register 0, and last_grantee NREQ-1 (so requester 0 has first priority).
REQ-024 rst asserted mid-RUN SHALL abort immediately with no done pulse; the first grant after release SHALL follow REQ-012 from the reset pointer.

Structure
REQ-025 A shared package cntr_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default NREQ and CW constants.
REQ-026 The counter datapath (clear, enable, terminal compare, count output) SHALL be a sub-module named cntr_core; arbitration and the FSM SHALL remain in cntr_arb.

Verification
REQ-027 Single run: rst then release, req=4'b0001, len0=3 -> gnt=0001 for 4 cycles with count 0,1,2,3, then done=0001 for one cycle and gnt=0.
REQ-028 Round robin: req=4'b1111 held, all len=1 -> grant order 0,1,2,3,0 with done pulses in that order, each grant 2 cycles long.
REQ-029 Boundary: len0=0 -> one RUN cycle with count=0 and a done pulse; len0=15 -> count reaches 15 and does not wrap, done follows.
REQ-030 Abort: req0 dropped while count=2 (len0=7) -> gnt=0 next cycle, count stays 2, no done, and requester 1 (req1=1) is granted next.
REQ-031 Reset mid-run: rst pulsed at count=5 -> gnt, done, busy and count go to 0 immediately; after release with req=4'b1010, requester 1 is granted first.
REQ-032 len change: len0 changed from 2 to 9 during RUN -> the run still ends at count=2.
